// File: rtl/metro_pkg.sv
// Shared definitions for the metro gate scheduler: status codes, FSM
// state encoding and small arithmetic helpers.
package metro_pkg;

  // Codes presented on status[2:0] to the seven-segment coder
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_DENIED  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;
  localparam logic [2:0] ST_PASSED  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    CHECK = 3'd2,
    OPEN  = 3'd3,
    DENY  = 3'd4
  } state_t;

  // Lane index after v, wrapping at n
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // 8-bit saturating increment for the statistics counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/metro_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around the lane count.
module metro_rr_arb
  import metro_pkg::*;
#(
  parameter int N_GATES = 4,
  parameter int IW      = $clog2(N_GATES)
) (
  input  logic [N_GATES-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [N_GATES-1:0] win,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit wins
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    win     = '0;
    for (int i = N_GATES - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N_GATES);
      if (req[cand]) begin
        win_idx = cand;
        any     = 1'b1;
      end
    end
    if (any) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/metro_gate_sched.sv
// Round-robin scheduler sharing one fare-validation path across N turnstile
// lanes: grant -> capture balance -> check/deduct -> open gate -> pass/timeout.
// Optional build macro METRO_STATS_EN adds saturating pass/deny counters.
module metro_gate_sched
  import metro_pkg::*;
#(
  parameter int N_GATES    = 4,
  parameter int BAL_W      = 3,
  parameter int FARE       = 2,
  parameter int OPEN_TICKS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_GATES-1:0]       req,
  input  logic [N_GATES*BAL_W-1:0] bal_in,
  input  logic [N_GATES-1:0]       pass_done,
  output logic [N_GATES-1:0]       gnt,
  output logic [N_GATES-1:0]       gate_open,
  output logic [BAL_W-1:0]         new_bal,
  output logic                     new_bal_vld,
  output logic [2:0]               status,
  output logic                     busy
`ifdef METRO_STATS_EN
  ,
  output logic [7:0]               pass_cnt,
  output logic [7:0]               deny_cnt
`endif
);

  localparam int IW    = $clog2(N_GATES);
  localparam int CNT_W = (OPEN_TICKS > 1) ? $clog2(OPEN_TICKS) : 1;
  localparam logic [BAL_W-1:0] FARE_V    = BAL_W'(FARE);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OPEN_TICKS - 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win_q;
  logic [BAL_W-1:0]   bal_q;
  logic [CNT_W-1:0]   tick_q;

  logic [N_GATES-1:0] arb_win;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic               lane_req;
  logic               lane_pass;
  logic [BAL_W-1:0]   lane_bal;
  logic [IW-1:0]      ptr_nxt;

  metro_rr_arb #(.N_GATES(N_GATES), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  // Per-winner views of the lane inputs and the fairness pointer update
  always_comb begin
    lane_req  = req[win_q];
    lane_pass = pass_done[win_q];
    lane_bal  = bal_in[win_q*BAL_W +: BAL_W];
    ptr_nxt   = IW'(wrap_inc(int'(win_q), N_GATES));
  end

  // Scheduler FSM; all outputs registered so reset closes gates immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win_q       <= '0;
      bal_q       <= '0;
      tick_q      <= '0;
      gnt         <= '0;
      gate_open   <= '0;
      new_bal     <= '0;
      new_bal_vld <= 1'b0;
      status      <= ST_IDLE;
      busy        <= 1'b0;
`ifdef METRO_STATS_EN
      pass_cnt    <= '0;
      deny_cnt    <= '0;
`endif
    end else begin
      new_bal_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state  <= GRANT;
            win_q  <= arb_idx;
            gnt    <= arb_win;
            status <= ST_CHECK;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          // Card pulled before capture: give up the slot, nothing deducted
          if (!lane_req) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            status <= ST_IDLE;
            ptr    <= ptr_nxt;
          end else begin
            bal_q <= lane_bal;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bal_q >= FARE_V) begin
            state       <= OPEN;
            new_bal     <= bal_q - FARE_V;
            new_bal_vld <= 1'b1;
            status      <= ST_OPEN;
            gate_open   <= gnt;
            tick_q      <= '0;
          end else begin
            state  <= DENY;
            status <= ST_DENIED;
`ifdef METRO_STATS_EN
            deny_cnt <= sat_inc8(deny_cnt);
`endif
          end
        end
        OPEN: begin
          // Passage beats a coincident timeout
          if (lane_pass || tick_q == TICK_LAST) begin
            state     <= IDLE;
            gnt       <= '0;
            gate_open <= '0;
            busy      <= 1'b0;
            ptr       <= ptr_nxt;
            status    <= lane_pass ? ST_PASSED : ST_TIMEOUT;
`ifdef METRO_STATS_EN
            if (lane_pass) pass_cnt <= sat_inc8(pass_cnt);
            else           deny_cnt <= sat_inc8(deny_cnt);
`endif
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DENY: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
